uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` transmitter among `NREQ` byte-stream requesters. Requesters are served round-robin, one byte per grant. The block drives the transmitter's `data_i` / `byte_ready_i` / `t_byte_i` load-and-start handshake. `uart_tx` has no busy or done output, so the block times each serial frame itself from the baud parameters. It sits between the on-chip byte sources and the `uart_tx` instance.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and frame-timing helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} uart_arb_state_t;

  localparam int FRAME_BITS = 10;

  // Clocks spent on one serial frame at the given clock and baud rate.
  function automatic int frame_cycles(input real clock, input real baud);
    return int'(clock / baud) * FRAME_BITS;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: returns the first valid index after ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NREQ byte sources, timing each frame locally.
// Define UART_ARB_PACKET_LOCK_EN to hold the grant on one requester until its last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NREQ         = 4,
  parameter int  DW           = 8,
  parameter real CLOCK        = 100e6,
  parameter int  BAUD_RATE    = 20000000,
  parameter int  BAUD_COUNTER = int'(CLOCK / BAUD_RATE),
  parameter int  FRAME_CYCLES = BAUD_COUNTER * FRAME_BITS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*DW-1:0]      req_data_i,
  input  logic [NREQ-1:0]         req_last_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [DW-1:0]           tx_data_o,
  output logic                    tx_byte_ready_o,
  output logic                    tx_t_byte_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

  uart_arb_state_t state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            byte_ready_q, byte_ready_d;
  logic            t_byte_q, t_byte_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] eligible;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;

`ifdef UART_ARB_PACKET_LOCK_EN
  logic lock_q, lock_d;

  // A locked grant narrows arbitration to the owner of the open packet.
  assign eligible = lock_q ? (req_valid_i & (NREQ'(1) << grant_q)) : req_valid_i;
`else
  logic unused_last;

  assign unused_last = ^req_last_i;
  assign eligible    = req_valid_i;
`endif

  uart_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .valid (eligible),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    req_ready = '0;
`ifdef UART_ARB_PACKET_LOCK_EN
    lock_d    = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found && !rst_i) begin
          req_ready[pick_idx] = 1'b1;
          data_d  = req_data_i[int'(pick_idx)*DW +: DW];
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          state_d = LOAD;
`ifdef UART_ARB_PACKET_LOCK_EN
          lock_d  = !req_last_i[pick_idx];
`endif
        end
      end
      LOAD:  state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered from the next state so they line up with LOAD/START.
    byte_ready_d = (state_d == LOAD) || (state_d == START);
    t_byte_d     = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NREQ - 1);
      grant_q      <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      byte_ready_q <= byte_ready_d;
      t_byte_q     <= t_byte_d;
      busy_q       <= busy_d;
`ifdef UART_ARB_PACKET_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign req_ready_o     = req_ready;
  assign tx_data_o       = data_q;
  assign tx_byte_ready_o = byte_ready_q;
  assign tx_t_byte_o     = t_byte_q;
  assign busy_o          = busy_q;
  assign grant_id_o      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: grant-order table, directed corner sequences,
// and randomized traffic compared cycle by cycle against a frame-timeline reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int FC   = 50;
`ifdef UART_ARB_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NREQ-1:0]      req_valid_i = '0;
  logic [NREQ*DW-1:0]   req_data_i = '0;
  logic [NREQ-1:0]      req_last_i = '0;
  logic [NREQ-1:0]      req_ready_o;
  logic [DW-1:0]        tx_data_o;
  logic                 tx_byte_ready_o;
  logic                 tx_t_byte_o;
  logic                 busy_o;
  logic [1:0]           grant_id_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  uart_tx_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_data_i      (req_data_i),
    .req_last_i      (req_last_i),
    .req_ready_o     (req_ready_o),
    .tx_data_o       (tx_data_o),
    .tx_byte_ready_o (tx_byte_ready_o),
    .tx_t_byte_o     (tx_t_byte_o),
    .busy_o          (busy_o),
    .grant_id_o      (grant_id_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: cycles elapsed since the last accepted byte, plus pointer and lock.
  bit         m_ok = 1'b0;
  int         m_phase = 0;
  int         m_ptr = NREQ - 1;
  int         m_owner = 0;
  int         m_grant = 0;
  bit         m_lock = 1'b0;
  logic [7:0] m_data = '0;

  function automatic int modelPick(input logic [NREQ-1:0] v);
    int res;
    int k;
    res = -1;
    for (int i = 1; i <= NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (res < 0 && v[k] && !(m_lock && k != m_owner)) res = k;
    end
    return res;
  endfunction

  always @(posedge clk) begin : model_update
    int w;
    cyc++;
    if (rst_i) begin
      m_ok = 1'b1; m_phase = 0; m_ptr = NREQ - 1; m_owner = 0;
      m_grant = 0; m_lock = 1'b0; m_data = '0;
    end else if (m_phase == 0) begin
      w = modelPick(req_valid_i);
      if (w >= 0) begin
        m_data  = req_data_i[w*DW +: DW];
        m_grant = w;
        m_ptr   = w;
        m_owner = w;
        m_lock  = LOCK_EN && !req_last_i[w];
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase == FC + 2) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin : model_check
    logic [NREQ-1:0] er;
    logic [16:0]     act;
    logic [16:0]     exp;
    int w;
    if (m_ok) begin
      er = '0;
      w = modelPick(req_valid_i);
      if (!rst_i && m_phase == 0 && w >= 0) er[w] = 1'b1;
      exp = {er, m_data, (m_phase == 1 || m_phase == 2), (m_phase == 2), (m_phase != 0), 2'(m_grant)};
      act = {req_ready_o, tx_data_o, tx_byte_ready_o, tx_t_byte_o, busy_o, grant_id_o};
      checkOutput($sformatf("model cycle %0d {ready,data,br,tb,busy,gid}", cyc), int'(act), int'(exp));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                               input logic [NREQ*DW-1:0] d);
    req_valid_i = v;
    req_last_i  = l;
    req_data_i  = d;
  endtask

  task automatic resetDut();
    rst_i = 1'b1;
    applyStimulus('0, '0, '0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Waits (bounded) for the cycle in which some requester is accepted.
  task automatic waitAccept(output int g, output int at);
    int n;
    n = 0;
    g = -1;
    #1;
    while (req_ready_o == '0 && n < 400) begin
      tick();
      #1;
      n++;
    end
    at = cyc;
    if (req_ready_o == '0) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      checkOutput("ready_onehot", $countones(req_ready_o), 1);
      for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) g = i;
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    int              grant;
    int              gap;
  } vec_t;

  vec_t tbl[8];
  int   pkt_exp[5];

  initial begin : main
    int g, t, prev, b0;
    bit seen;
    logic [NREQ*DW-1:0] d;

    tbl[0] = '{4'b1111, 4'b1111, 0, -1};
    tbl[1] = '{4'b1111, 4'b1111, 1, 53};
    tbl[2] = '{4'b1111, 4'b1111, 2, 53};
    tbl[3] = '{4'b1111, 4'b1111, 3, 53};
    tbl[4] = '{4'b1111, 4'b1111, 0, 53};
    tbl[5] = '{4'b1111, 4'b1111, 1, 53};
    tbl[6] = '{4'b1010, 4'b1111, 3, 53};
    tbl[7] = '{4'b1010, 4'b1111, 1, 53};
`ifdef UART_ARB_PACKET_LOCK_EN
    pkt_exp = '{0, 0, 0, 2, 2};
`else
    pkt_exp = '{0, 2, 0, 2, 0};
`endif

    // Reset values, with every requester valid to exercise the forced-low ready.
    tick();
    applyStimulus(4'b1111, 4'b1111, 32'h11223344);
    tick();
    checkOutput("reset ready", int'(req_ready_o), 0);
    checkOutput("reset data", int'(tx_data_o), 0);
    checkOutput("reset byte_ready", int'(tx_byte_ready_o), 0);
    checkOutput("reset t_byte", int'(tx_t_byte_o), 0);
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset grant_id", int'(grant_id_o), 0);
    applyStimulus('0, '0, '0);
    rst_i = 1'b0;
    tick();

    $display("[TB] single requester");
    applyStimulus(4'b0001, 4'b1111, 32'h000000A5);
    waitAccept(g, t);
    checkOutput("single grant", g, 0);
    tick();
    applyStimulus('0, '0, '0);
    checkOutput("single data", int'(tx_data_o), 'hA5);
    checkOutput("single br@1", int'(tx_byte_ready_o), 1);
    checkOutput("single tb@1", int'(tx_t_byte_o), 0);
    tick();
    checkOutput("single br@2", int'(tx_byte_ready_o), 1);
    checkOutput("single tb@2", int'(tx_t_byte_o), 1);
    tick();
    checkOutput("single br@3", int'(tx_byte_ready_o), 0);
    checkOutput("single busy@3", int'(busy_o), 1);
    while (cyc < t + 52) tick();
    checkOutput("single busy@52", int'(busy_o), 1);
    tick();
    checkOutput("single busy@53", int'(busy_o), 0);
    checkOutput("single data hold", int'(tx_data_o), 'hA5);

    $display("[TB] round-robin table");
    resetDut();
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      applyStimulus(tbl[i].valid, tbl[i].last, d);
      waitAccept(g, t);
      checkOutput($sformatf("table%0d grant", i), g, tbl[i].grant);
      if (tbl[i].gap >= 0) checkOutput($sformatf("table%0d gap", i), t - prev, tbl[i].gap);
      prev = t;
      tick();
      checkOutput($sformatf("table%0d grant_id", i), int'(grant_id_o), tbl[i].grant);
      checkOutput($sformatf("table%0d data", i), int'(tx_data_o), int'(d[tbl[i].grant*DW +: DW]));
    end

    $display("[TB] packet versus byte mode");
    resetDut();
    b0 = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus({2'b01, 1'b0, b0 < 3}, {2'b11, 1'b1, b0 == 2}, {8'h44, 8'h33, 8'h22, 8'(8'h10 + b0)});
      waitAccept(g, t);
      checkOutput($sformatf("packet grant%0d", i), g, pkt_exp[i]);
      if (g == 0) b0++;
      tick();
    end

    $display("[TB] locked requester stall");
    resetDut();
    applyStimulus(4'b0001, 4'b0000, 32'h000000C1);
    waitAccept(g, prev);
    checkOutput("stall first grant", g, 0);
    tick();
    applyStimulus(4'b0010, 4'b1110, 32'h0000D200);
`ifdef UART_ARB_PACKET_LOCK_EN
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_ready_o[1]) seen = 1'b1;
    end
    checkOutput("stall no grant to req1", int'(seen), 0);
    checkOutput("stall idle", int'(busy_o), 0);
    applyStimulus(4'b0011, 4'b1111, 32'h0000D2C2);
    waitAccept(g, t);
    checkOutput("stall last byte grant", g, 0);
    tick();
    applyStimulus(4'b0010, 4'b1111, 32'h0000D200);
    waitAccept(g, t);
    checkOutput("stall then req1", g, 1);
`else
    seen = 1'b0;
    waitAccept(g, t);
    checkOutput("byte mode req1 grant", g, 1);
    checkOutput("byte mode req1 gap", t - prev, 53);
`endif
    tick();

    $display("[TB] reset mid-frame");
    resetDut();
    applyStimulus(4'b0100, 4'b1111, 32'h00E30000);
    waitAccept(g, t);
    checkOutput("midreset grant", g, 2);
    tick();
    applyStimulus('0, '0, '0);
    while (cyc < t + 20) tick();
    rst_i = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 32'h5A5A5A5A);
    tick();
    checkOutput("midreset ready", int'(req_ready_o), 0);
    checkOutput("midreset data", int'(tx_data_o), 0);
    checkOutput("midreset br", int'(tx_byte_ready_o), 0);
    checkOutput("midreset tb", int'(tx_t_byte_o), 0);
    checkOutput("midreset busy", int'(busy_o), 0);
    checkOutput("midreset grant_id", int'(grant_id_o), 0);
    tick();
    checkOutput("midreset ready held", int'(req_ready_o), 0);
    rst_i = 1'b0;
    waitAccept(g, t);
    checkOutput("post-reset first grant", g, 0);
    tick();

    $display("[TB] randomized traffic");
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      logic [NREQ-1:0] l;
      for (int k = 0; k < NREQ; k++) l[k] = ($urandom_range(0, 3) != 0);
      d = $urandom;
      applyStimulus(4'($urandom_range(0, 15)), l, d);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
